// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl: digit-serial BCD adder, one digit per cycle through a shared adder.
// Define BCD_SUB_EN to add a sub port for nines-complement subtraction.
module bcd_serial_add_ctrl #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] A,
  input  logic [4*NDIG-1:0] B,
  input  logic              cin,
`ifdef BCD_SUB_EN
  input  logic              sub,
`endif
  output logic [4*NDIG-1:0] sum,
  output logic              ov_flag,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [4*NDIG-1:0] a_q, b_q, b_eff;
  logic [3:0] idx, a_d, b_d, dig;
  logic [4:0] raw;
  logic carry, c_nxt, sub_in, sub_q, bad, last, go;
`ifdef BCD_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif
  assign go = state == IDLE && start;
  assign last = idx == 4'(NDIG - 1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign nxt = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  // operand screening and B complementing happen once, at latch time
  always_comb begin
    bad = 1'b0;
    b_eff = B;
    a_d = '0;
    b_d = '0;
    for (int i = 0; i < NDIG; i++) begin
      bad = bad | (A[4*i +: 4] > 4'd9) | (B[4*i +: 4] > 4'd9);
      if (sub_in) b_eff[4*i +: 4] = 4'd9 - B[4*i +: 4];
      if (idx == 4'(i)) begin
        a_d = a_q[4*i +: 4];
        b_d = b_q[4*i +: 4];
      end
    end
  end
  assign raw = 5'(a_d) + 5'(b_d) + 5'(carry);
  assign c_nxt = raw > 5'd9;
  assign dig = c_nxt ? 4'(raw + 5'd6) : raw[3:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sub_q <= 1'b0;
      sum <= '0;
      ov_flag <= 1'b0;
      err <= 1'b0;
      idx <= '0;
      carry <= 1'b0;
    end else begin
      state <= nxt;
      if (go) begin
        a_q <= A;
        b_q <= b_eff;
        sub_q <= sub_in;
        sum <= '0;
        idx <= '0;
        carry <= sub_in ? ~cin : cin;
        err <= bad;
      end else if (state == RUN) begin
        for (int i = 0; i < NDIG; i++)
          if (idx == 4'(i)) sum[4*i +: 4] <= dig;
        carry <= c_nxt;
        idx <= idx + 4'd1;
        if (last) ov_flag <= sub_q ? ~c_nxt : c_nxt;
      end
    end
  end
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb_bcd_serial_add_ctrl: directed checks of the serial BCD adder; sub cases need BCD_SUB_EN.
module tb_bcd_serial_add_ctrl;
  logic clk, rst_n, start, cin;
  logic [15:0] A, B, sum;
  logic ov_flag, busy, done, err;
`ifdef BCD_SUB_EN
  logic sub;
`endif
  int checks = 0;
  int errors = 0;

  bcd_serial_add_ctrl #(.NDIG(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .cin(cin),
`ifdef BCD_SUB_EN
    .sub(sub),
`endif
    .sum(sum), .ov_flag(ov_flag), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the FSM is back in IDLE
  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c,
                    input logic s, input logic [15:0] es, input logic eo, input logic ee);
    int n;
    A = a; B = b; cin = c; start = 1'b1;
`ifdef BCD_SUB_EN
    sub = s;
`else
    if (s) $display("note: %s needs subtraction support", tag);
`endif
    @(negedge clk);
    start = 1'b0;
    n = 1;
    chk({tag, "_busy"}, 32'(busy), 1);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 5);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_ov"}, 32'(ov_flag), 32'(eo));
    chk({tag, "_err"}, 32'(err), 32'(ee));
    @(negedge clk);
    chk({tag, "_done1"}, 32'(done), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
    chk({tag, "_hold"}, 32'(sum), 32'(es));
  endtask

  initial begin
    int n, t1, t2, dcnt;
    rst_n = 1'b1; start = 1'b0; A = '0; B = '0; cin = 1'b0;
`ifdef BCD_SUB_EN
    sub = 1'b0;
`endif
    #3 rst_n = 1'b0;
    #1;
    chk("rst_sum", 32'(sum), 0);
    chk("rst_ov", 32'(ov_flag), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op("add1", 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0);
    op("wrap", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op("cin", 16'h0999, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
    op("bad", 16'h00A0, 16'h0001, 1'b0, 1'b0, 16'h0101, 1'b0, 1'b1);
    op("clean", 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    // a start pulse inside RUN must not queue a second operation
    A = 16'h1111; B = 16'h2222; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; A = 16'h0000; B = 16'h0000;
    @(negedge clk); start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("ign_dones", 32'(dcnt), 1);
    chk("ign_sum", 32'(sum), 32'h3333);
    chk("ign_idle", 32'(busy), 0);

    // held start runs back-to-back operations
    A = 16'h0001; B = 16'h0001; start = 1'b1;
    n = 0; t1 = -1; t2 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (done) begin
        if (t1 < 0) t1 = n;
        else if (t2 < 0) t2 = n;
      end
    end
    chk("b2b_first", 32'(t1), 5);
    chk("b2b_period", 32'(t2 - t1), 6);
    chk("b2b_sum", 32'(sum), 32'h0002);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("b2b_idle", 32'(busy), 0);

    // reset in the second RUN cycle aborts with no done
    A = 16'h00A5; B = 16'h0003; cin = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("abort_pre", 32'(sum[3:0]), 32'h9);
    rst_n = 1'b0;
    #1;
    chk("abort_sum", 32'(sum), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_err", 32'(err), 0);
    chk("abort_ov", 32'(ov_flag), 0);
    chk("abort_done", 32'(done), 0);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (done) dcnt++;
    end
    chk("abort_nodone", 32'(dcnt), 0);
    op("post", 16'h4321, 16'h1234, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

`ifdef BCD_SUB_EN
    op("sub1", 16'h0100, 16'h0001, 1'b0, 1'b1, 16'h0099, 1'b0, 1'b0);
    op("sub2", 16'h0001, 16'h0002, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0);
    op("addb", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_serial_add_ctrl.md
BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

Interface
REQ-001 SHALL have parameter NDIG, default 4, giving the number of BCD digits per operand; legal range is 1..8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request one operation; sampled only in IDLE.
REQ-005 SHALL have port A, input, 4*NDIG bits: packed BCD operand A, digit 0 in bits [3:0].
REQ-006 SHALL have port B, input, 4*NDIG bits: packed BCD operand B, same packing as A.
REQ-007 SHALL have port cin, input, 1 bit: decimal carry-in (add) or borrow-in (sub).
REQ-008 SHALL have port sum, output, 4*NDIG bits: packed BCD result, registered.
REQ-009 SHALL have port ov_flag, output, 1 bit: decimal carry-out (add) or borrow-out (sub), registered.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when sum and ov_flag are valid.
REQ-012 SHALL have port err, output, 1 bit: high if any latched operand digit is greater than 9.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
- IDLE to RUN on start=1.
- RUN to DONE after NDIG digit cycles.
- DONE to IDLE unconditionally.
REQ-014 SHALL, at the edge where start=1 is sampled in IDLE, perform all of the following:
- latch A and B;
- clear sum;
- set digit index to 0;
- set the internal carry to cin (add) or ~cin (sub);
- compute err from the latched operands.
REQ-015 SHALL process exactly one digit per RUN cycle, from index 0 upward, through one shared single-digit BCD adder.
REQ-016 SHALL compute each digit as raw = a_i + b_i + carry (5 bits).
- If raw > 9: digit = (raw + 6) mod 16 and carry = 1.
- Otherwise: digit = raw and carry = 0.
REQ-017 SHALL write sum digit i at the edge ending RUN cycle i; digit i SHALL NOT change afterwards until the next start.
REQ-018 SHALL have this latency: with start sampled at edge 0, done=1 during the cycle after edge NDIG, and busy=0 after edge NDIG+1.
REQ-019 SHALL, in add mode, set ov_flag to the final carry at the edge ending the last RUN cycle.
REQ-020 SHALL hold sum, ov_flag and err stable from DONE until the next accepted start.
REQ-021 SHALL ignore start while busy=1; an ignored start is not queued.
REQ-022 SHALL still perform the operation when an operand has an illegal digit (>9), using the REQ-016 formula, with err=1.
REQ-023 SHALL assert done for exactly one cycle per accepted start.
REQ-024 SHALL accept start=1 held continuously as back-to-back operations, one every NDIG+2 cycles.

Reset
REQ-025 SHALL, while rst_n=0, immediately force all of the following regardless of clk:
- state = IDLE;
- sum = 0, ov_flag = 0, busy = 0, done = 0, err = 0;
- digit index = 0 and internal carry = 0.
REQ-026 SHALL abort an operation when reset is asserted during RUN or DONE; no done pulse follows the aborted operation.
REQ-027 SHALL sample start normally at the first rising clk edge after rst_n deasserts.

Configuration
REQ-028 SHALL support the macro BCD_SUB_EN.
REQ-029 SHALL, when BCD_SUB_EN is defined, add port sub (input, 1 bit), latched with the operands, with these effects when sub=1:
- B digits are replaced by their nines complement (9 - b_i);
- the initial carry is ~cin;
- ov_flag = ~(final carry), i.e. borrow;
- a negative result appears in ten's complement.
REQ-030 SHALL, when BCD_SUB_EN is not defined, omit port sub and always add; behaviour is then identical to sub=0.

Verification
REQ-031 SHALL cover: NDIG=4, A=0x1234, B=0x5678, cin=0 -> sum=0x6912, ov_flag=0, done on the 5th cycle after the start edge.
REQ-032 SHALL cover: A=0x9999, B=0x0001, cin=0 -> sum=0x0000, ov_flag=1; then A=0x0999, B=0x0000, cin=1 -> sum=0x1000, ov_flag=0.
REQ-033 SHALL cover: A=0x00A0, B=0x0001 -> err=1, done still pulses once, sum=0x0101 per the REQ-016 formula (digit 1: raw=10 gives digit 0, carry 1).
REQ-034 SHALL cover: start pulsed during RUN -> ignored, exactly one done; start held high -> done every 6 cycles.
REQ-035 SHALL cover: rst_n pulled low in the 2nd RUN cycle -> all outputs 0 immediately, no done; a new start after release completes correctly.
REQ-036 SHALL cover, with BCD_SUB_EN and cin=0:
- sub=1, A=0x0100, B=0x0001 -> sum=0x0099, ov_flag=0;
- sub=1, A=0x0001, B=0x0002 -> sum=0x9999, ov_flag=1.
